// File: rtl/term_mode_pkg.sv
// Package term_mode_pkg
// Purpose: shared types and constants for the terminal-mode register bank.
//   - mode_op_t     : command opcodes issued by the escape-sequence parser
//   - mode_entry_t  : one row of the Pn-to-mode-bit table
//   - MODE_TABLE    : supported Pn codes (ANSI and DEC private spaces)
//   - MODE_DEFAULT  : power-on / soft-reset mode vector
//   - pnMask        : Pn lookup in one parameter space, returns a one-hot bit mask
//   - pnStatus      : report status (unknown / set / reset) for a Pn
package term_mode_pkg;

    localparam int unsigned MODE_W    = 8;
    localparam int unsigned IDX_W     = 3;
    localparam int unsigned TABLE_LEN = 8;

    // Named bit positions inside term_mode
    localparam int unsigned ORIGIN   = 0;
    localparam int unsigned AUTOWRAP = 1;
    localparam int unsigned INSERT   = 2;
    localparam int unsigned LNM      = 3;
    localparam int unsigned BLINK    = 4;
    localparam int unsigned VISIBLE  = 5;
    localparam int unsigned SRM      = 6;
    localparam int unsigned KAM      = 7;

    localparam logic [1:0] RPT_UNKNOWN = 2'd0;
    localparam logic [1:0] RPT_SET     = 2'd1;
    localparam logic [1:0] RPT_RESET   = 2'd2;

    typedef enum logic [3:0] {
        INIT_PN  = 4'd0,
        EMIT_PN  = 4'd1,
        SET_ANSI = 4'd2,
        RST_ANSI = 4'd3,
        SET_DEC  = 4'd4,
        RST_DEC  = 4'd5,
        SAVE     = 4'd6,
        RESTORE  = 4'd7,
        SOFT_RST = 4'd8,
        QUERY    = 4'd9
    } mode_op_t;

    typedef struct packed {
        logic [7:0]       code;
        logic             is_dec;
        logic [IDX_W-1:0] bit_idx;
    } mode_entry_t;

    // Pn 12 exists in both spaces (DEC blink, ANSI SRM)
    localparam mode_entry_t MODE_TABLE [TABLE_LEN] = '{
        '{8'd6,  1'b1, IDX_W'(ORIGIN)},
        '{8'd7,  1'b1, IDX_W'(AUTOWRAP)},
        '{8'd4,  1'b0, IDX_W'(INSERT)},
        '{8'd20, 1'b0, IDX_W'(LNM)},
        '{8'd12, 1'b1, IDX_W'(BLINK)},
        '{8'd25, 1'b1, IDX_W'(VISIBLE)},
        '{8'd12, 1'b0, IDX_W'(SRM)},
        '{8'd2,  1'b0, IDX_W'(KAM)}
    };

    localparam logic [MODE_W-1:0] MODE_DEFAULT =
        (MODE_W'(1) << AUTOWRAP) | (MODE_W'(1) << VISIBLE);

    function automatic logic [MODE_W-1:0] pnMask(input logic [7:0] pn, input logic isDec);
        logic [MODE_W-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < TABLE_LEN; i++) begin
            if (MODE_TABLE[i].code == pn && MODE_TABLE[i].is_dec == isDec) begin
                m[MODE_TABLE[i].bit_idx] = 1'b1;
            end
        end
        return m;
    endfunction

    // A Pn present in both spaces reports its DEC-private bit
    function automatic logic [1:0] pnStatus(input logic [7:0] pn, input logic [MODE_W-1:0] mode);
        logic [MODE_W-1:0] m;
        m = pnMask(pn, 1'b1);
        if (m == '0) begin
            m = pnMask(pn, 1'b0);
        end
        if (m == '0) begin
            return RPT_UNKNOWN;
        end
        return ((mode & m) != '0) ? RPT_SET : RPT_RESET;
    endfunction

endpackage

// File: rtl/term_mode_bank_if.sv
// Interface term_mode_bank_if
// Purpose: command / status / report bundle between parser (master) and mode bank (slave).
//   cmd_valid/cmd_ready/cmd_op/cmd_pn : command handshake
//   term_mode, unknown_pn, stack_err   : mode vector and event pulses
//   rpt_valid/rpt_ready/rpt_code/rpt_status : mode report handshake
interface term_mode_bank_if #(parameter int unsigned NUM_MODES = 8);
    import term_mode_pkg::*;

    logic                 cmd_valid;
    logic                 cmd_ready;
    mode_op_t             cmd_op;
    logic [7:0]           cmd_pn;
    logic [NUM_MODES-1:0] term_mode;
    logic                 unknown_pn;
    logic                 stack_err;
    logic                 rpt_valid;
    logic                 rpt_ready;
    logic [7:0]           rpt_code;
    logic [1:0]           rpt_status;

    modport master (
        output cmd_valid, cmd_op, cmd_pn, rpt_ready,
        input  cmd_ready, term_mode, unknown_pn, stack_err, rpt_valid, rpt_code, rpt_status
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_pn, rpt_ready,
        output cmd_ready, term_mode, unknown_pn, stack_err, rpt_valid, rpt_code, rpt_status
    );

endinterface

// File: rtl/mode_save_stack.sv
// Module mode_save_stack
// Purpose: circular LIFO of saved mode vectors; a push into a full stack overwrites the oldest.
// Ports: clk, rst (async active-high), push, pop, din -> dout (top entry, combinational),
//        empty, full, dropped (push while full, combinational)
module mode_save_stack #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full,
    output logic             dropped
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] topPtr;
    logic [PTR_W-1:0] nextPtr;
    logic [CNT_W-1:0] count;

    assign topPtr  = (wrPtr == '0) ? PTR_W'(DEPTH - 1) : wrPtr - PTR_W'(1);
    assign nextPtr = (wrPtr == PTR_W'(DEPTH - 1)) ? '0 : wrPtr + PTR_W'(1);
    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign dropped = push && full;
    assign dout    = mem[topPtr];

    // Pointer and occupancy; count saturates when the oldest entry is overwritten
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr <= '0;
            count <= '0;
        end else if (push) begin
            wrPtr <= nextPtr;
            if (!full) begin
                count <= count + CNT_W'(1);
            end
        end else if (pop && !empty) begin
            wrPtr <= topPtr;
            count <= count - CNT_W'(1);
        end
    end

    // Storage array, no reset needed
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wrPtr] <= din;
        end
    end

endmodule

// File: rtl/term_mode_bank.sv
// Module term_mode_bank
// Purpose: terminal-mode register bank. Collects SM/RM/DECSET/DECRST Pn codes into pending
//          masks, applies them to term_mode, provides save/restore and soft reset.
// Ports: clk, rst (async active-high), bus (term_mode_bank_if.slave: command, status, report).
// Config: MODE_REPORT_EN enables QUERY mode reports; when undefined the rpt_* outputs are 0.
module term_mode_bank
    import term_mode_pkg::*;
#(
    parameter int unsigned NUM_MODES  = 8,
    parameter int unsigned SAVE_DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    term_mode_bank_if.slave bus
);
    typedef enum logic [1:0] {IDLE, APPLY, REPORT} state_t;

    state_t               state;
    logic                 cmdReady;
    logic [NUM_MODES-1:0] termMode;
    logic [NUM_MODES-1:0] pendAnsi;
    logic [NUM_MODES-1:0] pendDec;
    logic                 applySet;
    logic                 applyDec;
    logic                 unknownPn;
    logic                 stackErr;

    logic                 accept;
    logic [NUM_MODES-1:0] ansiHit;
    logic [NUM_MODES-1:0] decHit;
    logic [NUM_MODES-1:0] applyMask;
    logic                 stackPush;
    logic                 stackPop;
    logic [NUM_MODES-1:0] stackTop;
    logic                 stackEmpty;
    logic                 stackFull;
    logic                 stackDropped;

    assign accept    = bus.cmd_valid && cmdReady;
    assign ansiHit   = NUM_MODES'(pnMask(bus.cmd_pn, 1'b0));
    assign decHit    = NUM_MODES'(pnMask(bus.cmd_pn, 1'b1));
    assign applyMask = applyDec ? pendDec : pendAnsi;
    assign stackPush = accept && (bus.cmd_op == SAVE);
    assign stackPop  = accept && (bus.cmd_op == RESTORE) && !stackEmpty;

    mode_save_stack #(.DEPTH(SAVE_DEPTH), .WIDTH(NUM_MODES)) u_stack (
        .clk     (clk),
        .rst     (rst),
        .push    (stackPush),
        .pop     (stackPop),
        .din     (termMode),
        .dout    (stackTop),
        .empty   (stackEmpty),
        .full    (stackFull),
        .dropped (stackDropped)
    );

    assign bus.cmd_ready  = cmdReady;
    assign bus.term_mode  = termMode;
    assign bus.unknown_pn = unknownPn;
    assign bus.stack_err  = stackErr;

`ifdef MODE_REPORT_EN
    logic       rptValid;
    logic [7:0] rptCode;
    logic [1:0] rptStatus;
    assign bus.rpt_valid  = rptValid;
    assign bus.rpt_code   = rptCode;
    assign bus.rpt_status = rptStatus;
`else
    assign bus.rpt_valid  = 1'b0;
    assign bus.rpt_code   = 8'd0;
    assign bus.rpt_status = 2'd0;
`endif

    // Command FSM; pulses default low every cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cmdReady  <= 1'b1;
            termMode  <= NUM_MODES'(MODE_DEFAULT);
            pendAnsi  <= '0;
            pendDec   <= '0;
            applySet  <= 1'b0;
            applyDec  <= 1'b0;
            unknownPn <= 1'b0;
            stackErr  <= 1'b0;
`ifdef MODE_REPORT_EN
            rptValid  <= 1'b0;
            rptCode   <= 8'd0;
            rptStatus <= 2'd0;
`endif
        end else begin
            unknownPn <= 1'b0;
            stackErr  <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        case (bus.cmd_op)
                            INIT_PN: begin
                                pendAnsi <= '0;
                                pendDec  <= '0;
                            end
                            EMIT_PN: begin
                                pendAnsi  <= pendAnsi | ansiHit;
                                pendDec   <= pendDec | decHit;
                                unknownPn <= (ansiHit == '0) && (decHit == '0);
                            end
                            SET_ANSI, RST_ANSI, SET_DEC, RST_DEC: begin
                                pendAnsi  <= pendAnsi | ansiHit;
                                pendDec   <= pendDec | decHit;
                                unknownPn <= (ansiHit == '0) && (decHit == '0);
                                applySet  <= (bus.cmd_op == SET_ANSI) || (bus.cmd_op == SET_DEC);
                                applyDec  <= (bus.cmd_op == SET_DEC) || (bus.cmd_op == RST_DEC);
                                cmdReady  <= 1'b0;
                                state     <= APPLY;
                            end
                            SAVE: begin
                                stackErr <= stackDropped;
                            end
                            RESTORE: begin
                                if (stackEmpty) begin
                                    stackErr <= 1'b1;
                                end else begin
                                    termMode <= stackTop;
                                end
                            end
                            SOFT_RST: begin
                                termMode <= NUM_MODES'(MODE_DEFAULT);
                                pendAnsi <= '0;
                                pendDec  <= '0;
                            end
`ifdef MODE_REPORT_EN
                            QUERY: begin
                                rptCode   <= bus.cmd_pn;
                                rptStatus <= pnStatus(bus.cmd_pn, MODE_W'(termMode));
                                rptValid  <= 1'b1;
                                cmdReady  <= 1'b0;
                                state     <= REPORT;
                            end
`endif
                            default: ;
                        endcase
                    end
                end
                APPLY: begin
                    termMode <= applySet ? (termMode | applyMask) : (termMode & ~applyMask);
                    pendAnsi <= '0;
                    pendDec  <= '0;
                    cmdReady <= 1'b1;
                    state    <= IDLE;
                end
                REPORT: begin
`ifdef MODE_REPORT_EN
                    if (bus.rpt_ready) begin
                        rptValid <= 1'b0;
                        cmdReady <= 1'b1;
                        state    <= IDLE;
                    end
`else
                    cmdReady <= 1'b1;
                    state    <= IDLE;
`endif
                end
                default: begin
                    cmdReady <= 1'b1;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_term_mode_bank.sv
// Testbench tb_term_mode_bank
// Purpose: directed plus randomized commands against a behavioural model of the mode bank
//          (mode vector as a byte, pending masks, save stack as a bounded queue).
module tb_term_mode_bank;
    import term_mode_pkg::*;

    localparam int unsigned NM = 8;
    localparam int unsigned SD = 4;
    // AUTOWRAP (bit 1) and VISIBLE (bit 5) on at power-up
    localparam logic [7:0] DEF_MODE = 8'h22;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    term_mode_bank_if #(.NUM_MODES(NM)) bus ();

    term_mode_bank #(.NUM_MODES(NM), .SAVE_DEPTH(SD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    logic [7:0] mMode;
    logic [7:0] mPendA;
    logic [7:0] mPendD;
    logic [7:0] mStack [$];

    // Reference Pn table: returns mode bit index or -1
    function automatic int refIdx(input logic [7:0] pn, input bit dec);
        if (dec) begin
            case (pn)
                8'd6:    return 0;
                8'd7:    return 1;
                8'd12:   return 4;
                8'd25:   return 5;
                default: return -1;
            endcase
        end else begin
            case (pn)
                8'd2:    return 7;
                8'd4:    return 2;
                8'd12:   return 6;
                8'd20:   return 3;
                default: return -1;
            endcase
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        mMode  = DEF_MODE;
        mPendA = 8'h00;
        mPendD = 8'h00;
        mStack.delete();
    endtask

    // Issue one command from idle and check every cycle until the bank is idle again
    task automatic issue(input mode_op_t op, input logic [7:0] pn, input int hold);
        int ia;
        int id;
        int qi;
        logic expUnk;
        logic expErr;
        logic [7:0] prevMode;
        logic [7:0] mask;
        logic [1:0] expStat;
        ia = refIdx(pn, 1'b0);
        id = refIdx(pn, 1'b1);
        expUnk = 1'b0;
        expErr = 1'b0;
        prevMode = mMode;
        @(negedge clk);
        check("ready_before", 32'(bus.cmd_ready), 32'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_pn    = pn;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        if (op inside {EMIT_PN, SET_ANSI, RST_ANSI, SET_DEC, RST_DEC}) begin
            if (ia >= 0) mPendA[ia] = 1'b1;
            if (id >= 0) mPendD[id] = 1'b1;
            expUnk = (ia < 0) && (id < 0);
        end
        case (op)
            INIT_PN: begin
                mPendA = 8'h00;
                mPendD = 8'h00;
            end
            SAVE: begin
                if (mStack.size() == SD) begin
                    expErr = 1'b1;
                    void'(mStack.pop_front());
                end
                mStack.push_back(mMode);
            end
            RESTORE: begin
                if (mStack.size() == 0) expErr = 1'b1;
                else mMode = mStack.pop_back();
            end
            SOFT_RST: begin
                mMode  = DEF_MODE;
                mPendA = 8'h00;
                mPendD = 8'h00;
            end
            default: ;
        endcase
        check("unknown_pn", 32'(bus.unknown_pn), 32'(expUnk));
        check("stack_err", 32'(bus.stack_err), 32'(expErr));
        if (op inside {SET_ANSI, RST_ANSI, SET_DEC, RST_DEC}) begin
            check("mode_before_apply", 32'(bus.term_mode), 32'(prevMode));
            check("ready_in_apply", 32'(bus.cmd_ready), 32'd0);
            @(posedge clk);
            #1;
            mask = (op inside {SET_ANSI, RST_ANSI}) ? mPendA : mPendD;
            if (op inside {SET_ANSI, SET_DEC}) mMode = mMode | mask;
            else mMode = mMode & ~mask;
            mPendA = 8'h00;
            mPendD = 8'h00;
            check("mode_after_apply", 32'(bus.term_mode), 32'(mMode));
            check("ready_after_apply", 32'(bus.cmd_ready), 32'd1);
            check("unknown_after_apply", 32'(bus.unknown_pn), 32'd0);
        end else if (op == QUERY) begin
`ifdef MODE_REPORT_EN
            qi = (id >= 0) ? id : ia;
            if (qi < 0) expStat = 2'd0;
            else expStat = mMode[qi] ? 2'd1 : 2'd2;
            for (int c = 0; c <= hold; c++) begin
                check("rpt_valid_held", 32'(bus.rpt_valid), 32'd1);
                check("rpt_code", 32'(bus.rpt_code), 32'(pn));
                check("rpt_status", 32'(bus.rpt_status), 32'(expStat));
                check("ready_in_report", 32'(bus.cmd_ready), 32'd0);
                if (c < hold) begin
                    @(posedge clk);
                    #1;
                end
            end
            @(negedge clk);
            bus.rpt_ready = 1'b1;
            @(posedge clk);
            #1;
            bus.rpt_ready = 1'b0;
            check("rpt_valid_drop", 32'(bus.rpt_valid), 32'd0);
            check("ready_after_report", 32'(bus.cmd_ready), 32'd1);
`else
            qi = hold;
            expStat = 2'(qi);
            check("rpt_valid_off", 32'(bus.rpt_valid), 32'd0);
            check("rpt_code_off", 32'(bus.rpt_code), 32'd0);
            check("ready_query_off", 32'(bus.cmd_ready), 32'd1);
`endif
            check("mode_after_query", 32'(bus.term_mode), 32'(mMode));
        end else begin
            check("mode", 32'(bus.term_mode), 32'(mMode));
            check("ready_single", 32'(bus.cmd_ready), 32'd1);
            check("rpt_idle", 32'(bus.rpt_valid), 32'd0);
        end
    endtask

    initial begin
        logic [7:0] pnList [8];
        mode_op_t rop;
        logic [7:0] rpn;
        pnList = '{8'd2, 8'd4, 8'd6, 8'd7, 8'd12, 8'd20, 8'd25, 8'd99};
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = INIT_PN;
        bus.cmd_pn    = 8'd0;
        bus.rpt_ready = 1'b0;
        modelReset();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_mode", 32'(bus.term_mode), 32'(DEF_MODE));
        check("rst_ready", 32'(bus.cmd_ready), 32'd1);
        check("rst_rpt_valid", 32'(bus.rpt_valid), 32'd0);
        check("rst_rpt_code", 32'(bus.rpt_code), 32'd0);
        check("rst_rpt_status", 32'(bus.rpt_status), 32'd0);
        check("rst_unknown", 32'(bus.unknown_pn), 32'd0);
        check("rst_stack_err", 32'(bus.stack_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("idle_mode", 32'(bus.term_mode), 32'(DEF_MODE));

        // Fold pending DEC 7 then reset with 25: autowrap and visible clear
        issue(INIT_PN, 8'd0, 0);
        issue(EMIT_PN, 8'd7, 0);
        issue(RST_DEC, 8'd25, 0);
        check("autowrap_vis_clear", 32'(bus.term_mode & 8'h22), 32'd0);

        // Insert mode set, unknown Pn 99 leaves mode alone
        issue(SET_ANSI, 8'd4, 0);
        check("insert_set", 32'(bus.term_mode[2]), 32'd1);
        issue(RST_ANSI, 8'd99, 0);

        // Dual-space Pn 12 is applied only in the space of the op
        issue(EMIT_PN, 8'd12, 0);
        issue(SET_DEC, 8'd6, 0);

        // Save five states into a four-deep stack, restore five
        for (int i = 0; i < 5; i++) begin
            issue((i % 2 == 0) ? SET_DEC : RST_ANSI, pnList[i + 1], 0);
            issue(SAVE, 8'd0, 0);
        end
        for (int i = 0; i < 5; i++) begin
            issue(RESTORE, 8'd0, 0);
        end

        // Report on LNM after setting it, consumer stalls three cycles
        issue(SET_ANSI, 8'd20, 0);
        issue(QUERY, 8'd20, 3);
        issue(QUERY, 8'd99, 1);

        // Soft reset keeps the stack
        issue(SAVE, 8'd0, 0);
        issue(SOFT_RST, 8'd0, 0);
        issue(RESTORE, 8'd0, 0);

        // Unmapped opcode is ignored
        issue(mode_op_t'(4'd13), 8'd6, 0);

        // Reset in the middle of APPLY
        issue(SAVE, 8'd0, 0);
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = SET_DEC;
        bus.cmd_pn    = 8'd6;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        check("apply_busy", 32'(bus.cmd_ready), 32'd0);
        rst = 1'b1;
        #1;
        check("midrst_mode", 32'(bus.term_mode), 32'(DEF_MODE));
        check("midrst_ready", 32'(bus.cmd_ready), 32'd1);
        check("midrst_rpt", 32'(bus.rpt_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        modelReset();
        @(posedge clk);
        #1;
        check("post_rst_mode", 32'(bus.term_mode), 32'(DEF_MODE));
        issue(RESTORE, 8'd0, 0);

        // Randomized command stream
        for (int n = 0; n < 300; n++) begin
            rop = mode_op_t'(4'($urandom_range(0, 11)));
            if ($urandom_range(0, 7) == 0) rpn = 8'($urandom_range(0, 255));
            else rpn = pnList[$urandom_range(0, 7)];
            issue(rop, rpn, int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
